// File: rtl/bus_sync_arbiter.sv
// ---------------------------------------------------------------------------
// bus_sync_arbiter
//
// Four-way round-robin arbiter that launches one requester's data word onto
// an unsynchronised bus. The launched word then stays stable for a fixed hold
// window so that a downstream multi-flop data synchronizer, enabled by
// bus_enable, can safely capture it in another clock domain.
//
// The FSM has two states. In IDLE a pending request is captured at a rising
// edge. HOLD then lasts HOLD_CYCLES cycles, during which new requests are
// ignored. Requests are level-held by the requesters, so nothing is lost
// while the arbiter is busy.
//
// Parameters
//   BUS_WIDTH   : width of each requester word and of Unsync_bus
//   HOLD_CYCLES : busy cycles after each launch (legal range 2..255)
//
// Ports
//   CLK         : system clock, rising-edge active
//   RST         : asynchronous active-low reset
//   req[3:0]    : level requests, held until acknowledged
//   req_data    : requester i word at [i*BUS_WIDTH +: BUS_WIDTH]
//   ack[3:0]    : one-cycle pulse to the requester whose word was captured
//   Unsync_bus  : registered launched word (data synchronizer input)
//   bus_enable  : one-cycle launch pulse (data synchronizer enable)
//   grant_id    : index of the last granted requester
//   busy        : high while a launch is in its hold window
// ---------------------------------------------------------------------------
module bus_sync_arbiter #(
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [3:0]             req,
  input  logic [4*BUS_WIDTH-1:0] req_data,
  output logic [3:0]             ack,
  output logic [BUS_WIDTH-1:0]   Unsync_bus,
  output logic                   bus_enable,
  output logic [1:0]             grant_id,
  output logic                   busy
);

  // The counter only ever holds values up to HOLD_CYCLES-1.
  localparam int             CNT_W    = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [1:0]           last_grant, last_grant_nx;
  logic [1:0]           winner;
  logic [3:0]           ack_nx;
  logic                 bus_enable_nx;
  logic [BUS_WIDTH-1:0] bus_nx;
  logic [1:0]           grant_id_nx;

  // Round-robin search: starts one past the previous winner and wraps.
  // The 2-bit index wraps naturally, so offset 4 folds back onto last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign winner = rr_pick(req, last_grant);
  assign busy   = (state == HOLD);

  // Next-state and output decode
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    last_grant_nx = last_grant;
    ack_nx        = 4'b0000;
    bus_enable_nx = 1'b0;
    bus_nx        = Unsync_bus;
    grant_id_nx   = grant_id;
    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          bus_nx        = req_data[int'(winner)*BUS_WIDTH +: BUS_WIDTH];
          grant_id_nx   = winner;
          last_grant_nx = winner;
          ack_nx        = 4'b0001 << winner;
          bus_enable_nx = 1'b1;
          cnt_nx        = CNT_LOAD;
          state_nx      = HOLD;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and output registers. The launched word is also cleared on reset
  // so that the synchronizer sees a defined value after reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 2'd3;
      ack        <= 4'b0000;
      bus_enable <= 1'b0;
      Unsync_bus <= '0;
      grant_id   <= 2'd0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      last_grant <= last_grant_nx;
      ack        <= ack_nx;
      bus_enable <= bus_enable_nx;
      Unsync_bus <= bus_nx;
      grant_id   <= grant_id_nx;
    end
  end

endmodule

// File: tb/tb_bus_sync_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_sync_arbiter
//
// Scoreboard bench for bus_sync_arbiter (BUS_WIDTH = 8, HOLD_CYCLES = 4).
// A timestamp-based reference model predicts every launch from the arbiter's
// rules. It uses a cycle count, the earliest cycle a new capture may occur,
// and the last winner. Predicted launches are queued. A negedge monitor
// compares all outputs against the model every cycle and pops a queued launch
// whenever the DUT raises bus_enable.
// ---------------------------------------------------------------------------
module tb_bus_sync_arbiter;

  localparam int W    = 8;
  localparam int HOLD = 4;

  logic           CLK;
  logic           RST;
  logic [3:0]     req;
  logic [4*W-1:0] req_data;
  logic [3:0]     ack;
  logic [W-1:0]   Unsync_bus;
  logic           bus_enable;
  logic [1:0]     grant_id;
  logic           busy;

  bus_sync_arbiter #(.BUS_WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .Unsync_bus (Unsync_bus),
    .bus_enable (bus_enable),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int           id;
    logic [W-1:0] word;
    int           cyc;
  } launch_t;

  launch_t      exp_q[$];

  // Reference model state
  int           cyc_m    = 0;
  int           free_at  = 0;
  int           launch_m = -100;
  int           last_m   = 3;
  logic [W-1:0] exp_bus  = '0;
  logic [1:0]   exp_gid  = 2'd0;
  logic [3:0]   exp_ack  = 4'b0;
  logic         exp_en   = 1'b0;
  logic         exp_busy = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  logic [3:0] keep;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cyc_m    = 0;
      free_at  = 0;
      launch_m = -100;
      last_m   = 3;
      exp_bus  = '0;
      exp_gid  = 2'd0;
      exp_ack  = 4'b0;
      exp_en   = 1'b0;
      exp_busy = 1'b0;
      exp_q.delete();
    end else begin
      int w;
      int j;
      launch_t e;
      cyc_m   = cyc_m + 1;
      exp_ack = 4'b0;
      exp_en  = 1'b0;
      if (cyc_m >= free_at && req != 4'b0000) begin
        w = -1;
        for (int k = 1; k <= 4; k++) begin
          j = (last_m + k) % 4;
          if (w < 0 && req[j]) w = j;
        end
        exp_bus  = req_data[w*W +: W];
        exp_gid  = 2'(w);
        last_m   = w;
        exp_ack  = 4'(1 << w);
        exp_en   = 1'b1;
        launch_m = cyc_m;
        free_at  = cyc_m + HOLD + 1;
        e.id     = w;
        e.word   = req_data[w*W +: W];
        e.cyc    = cyc_m;
        exp_q.push_back(e);
      end
      exp_busy = (cyc_m >= launch_m) && (cyc_m < launch_m + HOLD);
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    n_total++;
    if (act !== expv) begin
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: all outputs every cycle, plus queued launches on bus_enable
  always @(negedge CLK) begin
    launch_t e;
    check("ack",        32'(ack),        32'(exp_ack));
    check("bus_enable", 32'(bus_enable), 32'(exp_en));
    check("Unsync_bus", 32'(Unsync_bus), 32'(exp_bus));
    check("grant_id",   32'(grant_id),   32'(exp_gid));
    check("busy",       32'(busy),       32'(exp_busy));
    if (bus_enable) begin
      if (exp_q.size() == 0) begin
        check("launch_expected", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("launch_grant", 32'(grant_id),   32'(e.id));
        check("launch_word",  32'(Unsync_bus), 32'(e.word));
        check("launch_ack",   32'(ack),        32'(1 << e.id));
        check("launch_cycle", 32'(cyc_m),      32'(e.cyc));
      end
    end else if (exp_q.size() != 0) begin
      check("launch_missing", 32'(0), 32'(1));
      exp_q.delete();
    end
  end

  // Requesters drop their request on ack unless marked to keep it.
  task automatic tick();
    @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (ack[i] && !keep[i]) req[i] = 1'b0;
    end
  endtask

  // Asserts reset mid-cycle, well before the next clock edge.
  task automatic do_reset(input int n);
    @(posedge CLK);
    #2 RST = 1'b0;
    repeat (n) @(posedge CLK);
    #3 RST = 1'b1;
  endtask

  initial begin
    RST      = 1'b0;
    req      = 4'b0;
    req_data = '0;
    keep     = 4'b0;
    repeat (3) @(posedge CLK);
    #3 RST = 1'b1;
    tick();
    tick();

    // Single request on requester 2
    req_data[2*W +: W] = 8'hA5;
    req = 4'b0100;
    repeat (8) tick();

    // All four held: rotation 0,1,2,3,0 spaced HOLD+1 cycles
    do_reset(2);
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    keep = 4'hF;
    req  = 4'hF;
    repeat (26) tick();
    req  = 4'b0;
    keep = 4'b0;
    repeat (6) tick();

    // Request raised during hold is served on return to IDLE
    do_reset(1);
    req = 4'b0001;
    tick();
    tick();
    req[1] = 1'b1;
    repeat (8) tick();

    // Reset during hold with requester 3 held
    req  = 4'b1000;
    keep = 4'b1000;
    tick();
    tick();
    do_reset(2);
    keep = 4'b0;
    repeat (8) tick();

    // Short pulse during hold is never granted
    req = 4'b0001;
    tick();
    tick();
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    repeat (6) tick();

    // Randomized traffic
    repeat (600) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req_data[i*W +: W] = W'($urandom);
          req[i]  = 1'b1;
          keep[i] = ($urandom_range(0, 3) == 0);
        end else if (req[i] && $urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        int r;
        r = $urandom_range(0, 3);
        req_data[r*W +: W] = W'($urandom);
      end
      if ($urandom_range(0, 149) == 0) begin
        do_reset(1 + $urandom_range(0, 2));
      end
      tick();
    end

    req  = 4'b0;
    keep = 4'b0;
    repeat (8) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_sync_arbiter.md
BUS_SYNC_ARBITER -- requirements
Module: bus_sync_arbiter

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 8, width of each requester's data word and of Unsync_bus.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 4, number of cycles the block stays busy after each launch; legal range 2..255.
REQ-003 Port CLK  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port RST  input  1  reset, asynchronous, active-low.
REQ-005 Port req  input  4  per-requester request, level; held by the requester until its ack.
REQ-006 Port req_data  input  4*BUS_WIDTH  requester i word at bits [i*BUS_WIDTH +: BUS_WIDTH].
REQ-007 Port ack  output  4  one-cycle pulse to the requester whose word was captured.
REQ-008 Port Unsync_bus  output  BUS_WIDTH  launched word, registered, feeds the data synchronizer.
REQ-009 Port bus_enable  output  1  one-cycle launch pulse, feeds the data synchronizer enable.
REQ-010 Port grant_id  output  2  index of the last granted requester.
REQ-011 Port busy  output  1  high while a launch is in its hold window.

Function
REQ-012 The FSM SHALL have two states: IDLE and HOLD, plus a hold counter sized for HOLD_CYCLES-1.
REQ-013 In IDLE, at a rising edge with req != 0, the block SHALL select the winner by round-robin, searching from (last_grant+1) mod 4 upward with wrap.
REQ-014 At that edge: Unsync_bus <= req_data[winner]; grant_id <= winner; last_grant <= winner; ack[winner] <= 1; bus_enable <= 1; counter <= HOLD_CYCLES-1; state <= HOLD.
REQ-015 ack and bus_enable SHALL each be high for exactly the one cycle following the capture edge; all other ack bits SHALL stay 0.
REQ-016 In HOLD, on each edge: if counter == 0 then state <= IDLE, else counter decrements.
REQ-017 busy SHALL equal (state == HOLD): high for HOLD_CYCLES cycles per launch.
REQ-018 Unsync_bus SHALL stay constant from the capture edge until the next capture edge: minimum HOLD_CYCLES+1 cycles.
REQ-019 Back-to-back launches with requests pending SHALL be spaced exactly HOLD_CYCLES+1 cycles.
REQ-020 Requests asserted or changed during HOLD SHALL be ignored until IDLE; no request is queued or lost, since req is level-held.
REQ-021 A requester keeping req high after its ack SHALL be treated as a new request and served in round-robin order.
REQ-022 A req deasserted before being granted SHALL receive no ack.
REQ-023 req_data SHALL be sampled only at the capture edge; later changes do not affect Unsync_bus.
REQ-024 In IDLE with req == 0, all outputs SHALL hold their values, except that ack and bus_enable are 0.

Reset
REQ-025 On RST low, the block SHALL immediately set: Unsync_bus = 0, bus_enable = 0, ack = 0, grant_id = 0, busy = 0, state = IDLE, counter = 0, last_grant = 3.
REQ-026 Reset during HOLD SHALL abort the launch with no further pulse.
REQ-027 After release, the first grant SHALL go to the lowest-index asserted request, starting the search from index 0.

Verification (HOLD_CYCLES = 4, BUS_WIDTH = 8)
REQ-028 Assert RST low mid-operation -> all outputs 0 within the same cycle, without waiting for CLK.
REQ-029 req = 4'b0100 with word2 = 8'hA5 in IDLE -> next cycle: ack = 4'b0100, bus_enable = 1, Unsync_bus = 8'hA5, grant_id = 2, busy = 1. bus_enable then falls after 1 cycle, busy falls after 4 cycles, and Unsync_bus stays A5.
REQ-030 req = 4'b1111 held, words 8'h11/22/33/44 -> grants in order 0,1,2,3,0, launches every 5 cycles, Unsync_bus = 11,22,33,44,11.
REQ-031 req[1] raised on the second HOLD cycle after grant 0 -> no ack until IDLE, then ack = 4'b0010 exactly 5 cycles after the first launch.
REQ-032 RST pulsed during HOLD with req = 4'b1000 held -> no ack during reset; after release, ack = 4'b1000 on the first IDLE capture, and grant_id = 3.
REQ-033 req[0] pulsed for 1 cycle during HOLD and dropped before IDLE -> no ack, no bus_enable, and Unsync_bus unchanged.
